// File: rtl/divide_unit.sv
// divide_unit: iterative 32-bit RV32M divider (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle, 32-cycle latency.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - request strobe, accepted only when idle or in the done cycle
//   a, b   - dividend / divisor, sampled with start
//   op     - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   result - registered quotient or remainder, held until next completion
//   busy   - operation in progress (start ignored)
//   done   - one-cycle completion pulse, result valid in the same cycle
//
// Optional feature: define DIVIDE_UNIT_EARLY_OUT_EN to resolve divide-by-zero
// and signed overflow in one cycle without entering the iterative loop.
module divide_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    DIVIDE_OP_DIV  = 2'b00,
    DIVIDE_OP_DIVU = 2'b01,
    DIVIDE_OP_REM  = 2'b10,
    DIVIDE_OP_REMU = 2'b11
  } op_t;

  typedef enum logic [1:0] {IDLE, CALC, SHORT, DONE} state_t;

  state_t      state;
  op_t         op_q;
  logic        neg_q, neg_r;
  logic [31:0] quo;   // dividend shifts out of the top, quotient bits enter at the bottom
  logic [31:0] dvs;   // divisor magnitude
  logic [31:0] rem;   // partial remainder; the 33rd bit lives only in the trial compare
  logic [4:0]  cnt;

  logic        signed_op, a_neg, b_neg, b_zero, is_rem_q, ge;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted;
  logic [31:0] rem_nx, quo_nx, q_fix, r_fix, early_res;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[31];
    b_neg     = signed_op & b[31];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    b_zero    = (b == '0);
    is_rem_q  = (op_q == DIVIDE_OP_REM) || (op_q == DIVIDE_OP_REMU);

    // Remainder is always below the divisor, so the low 32 bits of the
    // difference are exact whenever the trial subtract succeeds.
    shifted = {rem, quo[31]};
    ge      = (shifted >= {1'b0, dvs});
    rem_nx  = ge ? (shifted[31:0] - dvs) : shifted[31:0];
    quo_nx  = {quo[30:0], ge};
    q_fix   = neg_q ? -quo_nx : quo_nx;
    r_fix   = neg_r ? -rem_nx : rem_nx;

    // Special-case results from latched magnitudes: with dvs==0 the
    // remainder is the original dividend; otherwise this is signed overflow
    // where |a| = 0x80000000 is itself the quotient and the remainder is 0.
    if (is_rem_q)
      early_res = (dvs == '0) ? (neg_r ? -quo : quo) : '0;
    else
      early_res = (dvs == '0) ? '1 : quo;
  end

`ifdef DIVIDE_UNIT_EARLY_OUT_EN
  logic special;
  always_comb begin
    special = b_zero || (signed_op && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= DIVIDE_OP_DIV;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op_t'(op);
            quo   <= a_mag;
            dvs   <= b_mag;
            neg_q <= (a_neg ^ b_neg) & ~b_zero;
            neg_r <= a_neg;
            rem   <= '0;
            cnt   <= 5'd31;
`ifdef DIVIDE_UNIT_EARLY_OUT_EN
            if (special) begin
              state <= SHORT;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
`else
            state <= CALC;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 5'd1;
          if (cnt == '0) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= is_rem_q ? r_fix : q_fix;
          end
        end
        SHORT: begin
          state  <= DONE;
          done   <= 1'b1;
          result <= early_res;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// tb_divide_unit: self-checking bench for divide_unit with directed RV32M
// cases, random operands against an arithmetic reference model, back-to-back
// issue, ignored mid-operation start and reset during an operation.
module tb_divide_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  op = '0;
  logic [31:0] result;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  divide_unit dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V division semantics in plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
    case (o)
      2'b00: return sx / sy;
      2'b01: return x / y;
      2'b10: return sx % sy;
      default: return x % y;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIVIDE_UNIT_EARLY_OUT_EN
    if (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
`endif
    return 32;
  endfunction

  // Called away from the edge; start is sampled at the next rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!done && lat < 200);
    if (!done) check("timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_case(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat, el;
    logic [31:0] exp;
    exp = ref_div(o, x, y);
    el  = exp_latency(o, x, y);
    issue(o, x, y);
    check({tag, "_busy"}, {31'd0, busy}, (el > 1) ? 32'd1 : 32'd0);
    wait_done(lat);
    check({tag, "_lat"}, lat, el);
    check({tag, "_res"}, result, exp);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, result, exp);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] x, y;
    logic [1:0]  o;

    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_case("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_case("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_case("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7);
    run_case("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7);
    run_case("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9);
    run_case("div_by0", 2'b00, 32'h1234_5678, 32'd0);
    run_case("divu_by0", 2'b01, 32'h1234_5678, 32'd0);
    run_case("rem_by0", 2'b10, 32'h1234_5678, 32'd0);
    run_case("remu_by0", 2'b11, 32'h1234_5678, 32'd0);
    run_case("div_negby0", 2'b00, 32'h8765_4321, 32'd0);
    run_case("rem_negby0", 2'b10, 32'h8765_4321, 32'd0);
    run_case("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_case("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_case("divu_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

    // Back-to-back with an ignored mid-operation start.
    issue(2'b01, 32'hFFFF_FFFF, 32'h10);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    op = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    check("b2b_first_lat", 6 + lat, 32);
    check("b2b_first_res", result, 32'h0FFF_FFFF);
    issue(2'b11, 32'hFFFF_FFFF, 32'h10);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("b2b_second_lat", lat, 32);
    check("b2b_second_res", result, 32'h0000_000F);

    // Reset in the middle of an operation.
    issue(2'b01, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_idle", {30'd0, busy, done}, 32'd0);
    run_case("divu_9_3", 2'b01, 32'd9, 32'd3);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 20));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: y = -32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 1000));
      run_case("rand", o, x, y);
    end

    check("busy_done_excl", overlap, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
